mq_outgoing_slot: RTL and testbench
===================================

// Module: mq_outgoing_slot
// PURPOSE
//  CPU-to-host outgoing message-queue slot. Node CPU claims an entry, writes
//  payload, commits. Host, over the VME/WB bridge, polls count, reads the head
//  message, then discards it.
//  Sits between the CPU-side mqueue port and the host-side register window
//  that the host MQ driver polls.
// PARAMETERS
//  G_ENTRIES     8   messages held; power of two, >=2
//  G_WORDS       128 32-bit words per message; power of two
//  G_IRQ_THRESH  1   irq_o asserts when count >= this; range 1..G_ENTRIES
// PORTS
//  clk_i          in   1    system clock
//  rst_i          in   1    synchronous, active-high reset
//  src_claim_i    in   1    CPU: request the next free entry (pulse)
//  src_we_i       in   1    CPU: write a payload word into the claimed entry
//  src_addr_i     in   AW   CPU: word index, AW=$clog2(G_WORDS)
//  src_data_i     in   32   CPU: write data
//  src_commit_i   in   1    CPU: publish the claimed entry (pulse)
//  src_claimed_o  out  1    an entry is claimed and writable
//  src_full_o     out  1    count == G_ENTRIES
//  snk_addr_i     in   AW   host: word index into the head entry
//  snk_data_o     out  32   host: read data, 1-cycle latency
//  snk_discard_i  in   1    host: release the head entry (pulse)
//  snk_purge_i    in   1    host: flush the whole slot (pulse)
//  snk_count_o    out  CW   committed entries, CW=$clog2(G_ENTRIES)+1
//  snk_empty_o    out  1    count == 0
//  irq_o          out  1    registered, count >= G_IRQ_THRESH
// BEHAVIOUR
//  Reset or purge, with purge having priority over every other input:
//   - wr_ptr, rd_ptr, count and claimed are all set to 0.
//   - Outputs: src_claimed_o=0, src_full_o=0, snk_empty_o=1, irq_o=0,
//     snk_count_o=0, snk_data_o=0.
//   - RAM contents are not cleared.
//  Claim:
//   - Accepted only if !claimed && !src_full_o (registered value); then
//     claimed=1 on the next cycle.
//   - A claim while full or while already claimed is ignored.
//  Write:
//   - Only while claimed: RAM[wr_ptr*G_WORDS+src_addr_i] <= src_data_i.
//   - A write with no entry claimed is dropped.
//  Commit:
//   - Only while claimed: wr_ptr++ (mod G_ENTRIES), count++, claimed=0.
//   - A commit without a claim is ignored.
//   - A write and a commit in the same cycle: the write lands before the
//     entry is published.
//  Discard:
//   - Only if count>0: rd_ptr++ (mod G_ENTRIES), count--.
//   - A discard while empty is ignored.
//  Simultaneous events:
//   - Commit and discard together: count is unchanged and both pointers move.
//   - Claim and discard together while full: the claim is refused, because
//     full is judged on the registered count.
//   - Claim and commit together: the commit is applied and the claim is
//     ignored that cycle.
//  Read:
//   - snk_data_o <= RAM[rd_ptr*G_WORDS+snk_addr_i], registered, 1 cycle
//     latency.
//   - Reading while empty returns stale data, with no error.
//  Flags:
//   - src_full_o, snk_empty_o, snk_count_o and irq_o all update in the cycle
//     after the event that changed count.
//  Pointers wrap modulo G_ENTRIES and count never exceeds G_ENTRIES.
// CONFIGURATION
//  MQ_OUT_SLOT_STATS_EN
//   - Defined: adds output ports stat_overflow_o[15:0] and
//     stat_committed_o[15:0].
//   - stat_overflow_o counts claims refused because the slot was full; it
//     saturates at 16'hFFFF.
//   - stat_committed_o counts accepted commits and wraps.
//   - Both counters are cleared by reset or purge.
//  Undefined: these ports and the counter logic are absent; all other
//  behaviour is identical.
// STRUCTURE
//  Package mq_slot_pkg:
//   - c_MQ_DATA_W = 32.
//   - Function f_log2_ceil.
//   - typedef mq_slot_status_t {count, full, empty, claimed}, shared with the
//     host register-window block.
//  Sub-module mq_slot_dpram:
//   - Simple dual-port RAM, 1 write / 1 read port, registered read,
//     G_ENTRIES*G_WORDS x 32.
//  The top-level contains pointers, count, claim flag and flags only.
// TESTING
//  1. Reset; after 2 cycles -> count=0, empty=1, full=0, irq=0, claimed=0.
//  2. Claim, write words 0..2 = 1,2,3, commit -> count=1 next cycle, irq=1;
//     host reads addr 0..2 -> 1,2,3 one cycle each; discard -> count=0,
//     irq=0.
//  3. Fill all 8 entries, with word0 = entry index; 9th claim -> claimed
//     stays 0, full=1 (stat_overflow_o=1 with STATS_EN); discard 8 times,
//     reading word0 each time -> 0..7 in order.
//  4. With count=3 and an entry claimed, commit and discard in the same
//     cycle -> count stays 3, rd_ptr and wr_ptr both advance; run
//     3*G_ENTRIES such cycles to exercise pointer wrap-around, data intact.
//  5. Write and commit without a claim -> count unchanged, RAM unchanged;
//     discard while empty -> count stays 0.
//  6. Purge mid-operation, with count=5 and an entry claimed -> next cycle
//     count=0, claimed=0, irq=0; a fresh claim/commit works normally.

Source files
------------

// File: rtl/mq_slot_pkg.sv
// Shared types and helpers for the outgoing message-queue slot and its host register window.
// Latency: none (types/constants only). Backpressure: n/a.
package mq_slot_pkg;

  localparam int c_MQ_DATA_W = 32;
  localparam int c_STATUS_CW = 16;

  function automatic int f_log2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic [c_STATUS_CW-1:0] count;
    logic                   full;
    logic                   empty;
    logic                   claimed;
  } mq_slot_status_t;

  typedef enum logic {
    ST_FREE    = 1'b0,
    ST_CLAIMED = 1'b1
  } mq_claim_state_t;

endpackage

// File: rtl/mq_outgoing_slot_if.sv
// CPU-side (src) and host-side (snk) signal bundle of the outgoing message-queue slot.
// Latency: none (wiring only). Backpressure: src_full_o / src_claimed_o gate the CPU side.
interface mq_outgoing_slot_if #(
  parameter int AW = 7,
  parameter int CW = 4
);
  import mq_slot_pkg::*;

  logic                   src_claim_i;
  logic                   src_we_i;
  logic [AW-1:0]          src_addr_i;
  logic [c_MQ_DATA_W-1:0] src_data_i;
  logic                   src_commit_i;
  logic                   src_claimed_o;
  logic                   src_full_o;
  logic [AW-1:0]          snk_addr_i;
  logic [c_MQ_DATA_W-1:0] snk_data_o;
  logic                   snk_discard_i;
  logic                   snk_purge_i;
  logic [CW-1:0]          snk_count_o;
  logic                   snk_empty_o;
  logic                   irq_o;

  modport master (
    output src_claim_i, src_we_i, src_addr_i, src_data_i, src_commit_i,
    output snk_addr_i, snk_discard_i, snk_purge_i,
    input  src_claimed_o, src_full_o, snk_data_o, snk_count_o, snk_empty_o, irq_o
  );

  modport slave (
    input  src_claim_i, src_we_i, src_addr_i, src_data_i, src_commit_i,
    input  snk_addr_i, snk_discard_i, snk_purge_i,
    output src_claimed_o, src_full_o, snk_data_o, snk_count_o, snk_empty_o, irq_o
  );

endinterface

// File: rtl/mq_slot_dpram.sv
// Simple dual-port message RAM: one write port, one registered read port.
// Latency: read data 1 cycle after address. Backpressure: none, always accepts.
module mq_slot_dpram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // clr only zeroes the read register; array contents survive a flush
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (clr) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/mq_outgoing_slot.sv
// CPU-to-host outgoing message-queue slot (claim/write/commit, host read/discard/purge); optional MQ_OUT_SLOT_STATS_EN adds stat counters.
// Latency: read data 1 cycle; count/flags/irq update the cycle after the event. Backpressure: claims refused while full or already claimed.
module mq_outgoing_slot
  import mq_slot_pkg::*;
#(
  parameter int G_ENTRIES    = 8,
  parameter int G_WORDS      = 128,
  parameter int G_IRQ_THRESH = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mq_outgoing_slot_if.slave   bus
`ifdef MQ_OUT_SLOT_STATS_EN
  ,
  output logic [15:0]         stat_overflow_o,
  output logic [15:0]         stat_committed_o
`endif
);

  localparam int AW  = f_log2_ceil(G_WORDS);
  localparam int EW  = f_log2_ceil(G_ENTRIES);
  localparam int CW  = EW + 1;
  localparam int RAW = EW + AW;

  logic            clr;
  mq_claim_state_t state_q, state_d;
  logic [EW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, empty_q, irq_q;
  logic            commit_ok, discard_ok, wr_ok;

  // purge shares the reset path so it wins over every same-cycle input
  assign clr = rst_i | bus.snk_purge_i;

  always_comb begin
    state_d   = state_q;
    commit_ok = 1'b0;
    case (state_q)
      ST_FREE:    if (bus.src_claim_i && !full_q) state_d = ST_CLAIMED;
      ST_CLAIMED: if (bus.src_commit_i) begin
        state_d   = ST_FREE;
        commit_ok = 1'b1;
      end
      default:    state_d = ST_FREE;
    endcase
  end

  assign wr_ok      = (state_q == ST_CLAIMED) && bus.src_we_i;
  assign discard_ok = bus.snk_discard_i && !empty_q;
  assign count_d    = count_q + CW'(commit_ok) - CW'(discard_ok);

  always_ff @(posedge clk_i) begin
    if (clr) begin
      state_q  <= ST_FREE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      irq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (commit_ok)  wr_ptr_q <= wr_ptr_q + EW'(1);
      if (discard_ok) rd_ptr_q <= rd_ptr_q + EW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(G_ENTRIES));
      empty_q <= (count_d == '0);
      irq_q   <= (count_d >= CW'(G_IRQ_THRESH));
    end
  end

  // entry base is ptr*G_WORDS; G_WORDS is a power of two so concatenation suffices
  mq_slot_dpram #(
    .DEPTH (G_ENTRIES * G_WORDS),
    .AW    (RAW),
    .DW    (c_MQ_DATA_W)
  ) u_ram (
    .clk   (clk_i),
    .clr   (clr),
    .we    (wr_ok),
    .waddr ({wr_ptr_q, bus.src_addr_i}),
    .wdata (bus.src_data_i),
    .raddr ({rd_ptr_q, bus.snk_addr_i}),
    .rdata (bus.snk_data_o)
  );

  assign bus.src_claimed_o = (state_q == ST_CLAIMED);
  assign bus.src_full_o    = full_q;
  assign bus.snk_empty_o   = empty_q;
  assign bus.snk_count_o   = count_q;
  assign bus.irq_o         = irq_q;

`ifdef MQ_OUT_SLOT_STATS_EN
  always_ff @(posedge clk_i) begin
    if (clr) begin
      stat_overflow_o  <= '0;
      stat_committed_o <= '0;
    end else begin
      if (bus.src_claim_i && full_q && (stat_overflow_o != 16'hFFFF))
        stat_overflow_o <= stat_overflow_o + 16'd1;
      if (commit_ok) stat_committed_o <= stat_committed_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mq_outgoing_slot.sv
// Bench for mq_outgoing_slot: directed scenarios plus random traffic against a message-queue model.
module tb_mq_outgoing_slot;
  import mq_slot_pkg::*;

  localparam int N  = 8;
  localparam int W  = 128;
  localparam int TH = 1;
  localparam int AW = 7;
  localparam int CW = 4;

  // model message: words 0..3 with a mask of which were written
  typedef struct packed {
    logic [3:0]   mask;
    logic [127:0] words;
  } msg_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mq_outgoing_slot_if #(.AW(AW), .CW(CW)) bus ();

`ifdef MQ_OUT_SLOT_STATS_EN
  logic [15:0] st_ovf, st_cmt;
`endif

  mq_outgoing_slot #(
    .G_ENTRIES    (N),
    .G_WORDS      (W),
    .G_IRQ_THRESH (TH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef MQ_OUT_SLOT_STATS_EN
    ,
    .stat_overflow_o  (st_ovf),
    .stat_committed_o (st_cmt)
`endif
  );

  msg_t        q[$];
  msg_t        pend;
  bit          m_claimed;
  logic [31:0] m_data;
  bit          m_data_chk;
  logic [15:0] m_ovf, m_cmt;
  int          total = 0;
  int          bad   = 0;

  function automatic logic [CW+3:0] exp_status();
    return {CW'(q.size()), q.size() == N, q.size() == 0, q.size() >= TH, m_claimed};
  endfunction

  function automatic logic [CW+3:0] act_status();
    return {bus.snk_count_o, bus.src_full_o, bus.snk_empty_o, bus.irq_o, bus.src_claimed_o};
  endfunction

  // Drive one cycle of inputs, advance the model by the same event, sample 1 time unit after the edge.
  task automatic step(input bit claim, input bit we, input int waddr, input logic [31:0] wdata,
                      input bit commit, input int raddr, input bit discard, input bit purge);
    msg_t h;
    bit   full_pre, has_head;
    bus.src_claim_i   = claim;
    bus.src_we_i      = we;
    bus.src_addr_i    = AW'(waddr);
    bus.src_data_i    = wdata;
    bus.src_commit_i  = commit;
    bus.snk_addr_i    = AW'(raddr);
    bus.snk_discard_i = discard;
    bus.snk_purge_i   = purge;
    if (rst || purge) begin
      q.delete();
      m_claimed  = 1'b0;
      m_data     = '0;
      m_data_chk = 1'b1;
      m_ovf      = '0;
      m_cmt      = '0;
    end else begin
      full_pre   = (q.size() == N);
      has_head   = (q.size() > 0);
      m_data_chk = 1'b0;
      if (has_head && raddr < 4) begin
        h = q[0];
        if (h.mask[raddr]) begin
          m_data     = h.words[raddr*32 +: 32];
          m_data_chk = 1'b1;
        end
      end
      if (m_claimed && we && waddr < 4) begin
        pend.words[waddr*32 +: 32] = wdata;
        pend.mask[waddr]           = 1'b1;
      end
      if (claim && full_pre && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
      if (m_claimed && commit) begin
        q.push_back(pend);
        m_claimed = 1'b0;
        m_cmt     = m_cmt + 16'd1;
      end else if (claim && !m_claimed && !full_pre) begin
        m_claimed = 1'b1;
        pend      = '0;
      end
      if (has_head && discard) void'(q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    total++;
    if (act_status() !== exp_status()) begin
      bad++; $display("FAIL reset_status got=%b want=%b", act_status(), exp_status());
    end
    total++;
    if (bus.snk_data_o !== 32'd0) begin
      bad++; $display("FAIL reset_data got=%h want=0", bus.snk_data_o);
    end
  endtask

  task automatic test_single();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 1, k, 32'(k + 1), 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    total++;
    if (act_status() !== exp_status() || bus.snk_count_o !== 4'd1 || bus.irq_o !== 1'b1) begin
      bad++; $display("FAIL single_commit got=%b want=%b", act_status(), exp_status());
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, k, 0, 0);
      total++;
      if (bus.snk_data_o !== 32'(k + 1)) begin
        bad++; $display("FAIL single_read%0d got=%h want=%h", k, bus.snk_data_o, 32'(k + 1));
      end
    end
    step(0, 0, 0, 0, 0, 0, 1, 0);
    total++;
    if (act_status() !== exp_status() || bus.irq_o !== 1'b0) begin
      bad++; $display("FAIL single_discard got=%b want=%b", act_status(), exp_status());
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < N; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 32'(i), 1, 0, 0, 0);
    end
    total++;
    if (act_status() !== exp_status() || bus.src_full_o !== 1'b1) begin
      bad++; $display("FAIL fill_full got=%b want=%b", act_status(), exp_status());
    end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (act_status() !== exp_status() || bus.src_claimed_o !== 1'b0) begin
      bad++; $display("FAIL fill_claim_refused got=%b want=%b", act_status(), exp_status());
    end
`ifdef MQ_OUT_SLOT_STATS_EN
    total++;
    if (st_ovf !== m_ovf) begin
      bad++; $display("FAIL fill_overflow_stat got=%0d want=%0d", st_ovf, m_ovf);
    end
`endif
    for (int i = 0; i < N; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, 0);
      total++;
      if (bus.snk_data_o !== 32'(i)) begin
        bad++; $display("FAIL fill_drain%0d got=%h want=%h", i, bus.snk_data_o, 32'(i));
      end
    end
    total++;
    if (act_status() !== exp_status()) begin
      bad++; $display("FAIL fill_empty got=%b want=%b", act_status(), exp_status());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 32'(100 + i), 1, 0, 0, 0);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (act_status() !== exp_status() || bus.snk_count_o !== 4'd3) begin
      bad++; $display("FAIL b2b_setup got=%b want=%b", act_status(), exp_status());
    end
    for (int it = 0; it < 3 * N; it++) begin
      step(0, 1, 0, 32'(200 + it), 1, 0, 1, 0);
      total++;
      if (act_status() !== exp_status() || bus.snk_count_o !== 4'd3 ||
          bus.snk_data_o !== m_data) begin
        bad++; $display("FAIL b2b_iter%0d status=%b want=%b data=%h want=%h",
                        it, act_status(), exp_status(), bus.snk_data_o, m_data);
      end
      if (it != 3 * N - 1) step(1, 0, 0, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, 0);
      total++;
      if (bus.snk_data_o !== 32'(200 + 3 * N - 3 + i)) begin
        bad++; $display("FAIL b2b_drain%0d got=%h want=%h", i, bus.snk_data_o, 32'(200 + 3 * N - 3 + i));
      end
    end
  endtask

  task automatic test_no_claim();
    step(0, 1, 0, 32'hDEAD_BEEF, 1, 0, 0, 0);
    total++;
    if (act_status() !== exp_status() || bus.snk_count_o !== 4'd0) begin
      bad++; $display("FAIL noclaim_commit got=%b want=%b", act_status(), exp_status());
    end
    step(0, 0, 0, 0, 0, 0, 1, 0);
    total++;
    if (act_status() !== exp_status() || bus.snk_empty_o !== 1'b1) begin
      bad++; $display("FAIL empty_discard got=%b want=%b", act_status(), exp_status());
    end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h55, 1, 0, 0, 0);
    step(0, 1, 0, 32'hBAD, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (bus.snk_data_o !== 32'h55 || bus.snk_count_o !== 4'd1) begin
      bad++; $display("FAIL noclaim_write data=%h want=55 count=%0d want=1", bus.snk_data_o, bus.snk_count_o);
    end
    step(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_purge();
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 32'(300 + i), 1, 0, 0, 0);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (act_status() !== exp_status() || bus.snk_count_o !== 4'd5) begin
      bad++; $display("FAIL purge_setup got=%b want=%b", act_status(), exp_status());
    end
    step(1, 1, 0, 32'h1234, 1, 0, 1, 1);
    total++;
    if (act_status() !== exp_status() || bus.snk_count_o !== 4'd0 ||
        bus.irq_o !== 1'b0 || bus.src_claimed_o !== 1'b0 || bus.snk_data_o !== 32'd0) begin
      bad++; $display("FAIL purge status=%b want=%b data=%h", act_status(), exp_status(), bus.snk_data_o);
    end
`ifdef MQ_OUT_SLOT_STATS_EN
    total++;
    if (st_ovf !== 16'd0 || st_cmt !== 16'd0) begin
      bad++; $display("FAIL purge_stats got=%0d/%0d want=0/0", st_ovf, st_cmt);
    end
`endif
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h77, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    total++;
    if (bus.snk_data_o !== 32'h77 || act_status() !== exp_status()) begin
      bad++; $display("FAIL purge_after data=%h want=77 status=%b want=%b",
                      bus.snk_data_o, act_status(), exp_status());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 50, int'($urandom_range(0, 5)),
           $urandom, $urandom_range(0, 99) < 25, int'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 25, $urandom_range(0, 199) == 0);
      total++;
      if (act_status() !== exp_status()) begin
        bad++; $display("FAIL rand_status c=%0d got=%b want=%b", c, act_status(), exp_status());
      end
      if (m_data_chk) begin
        total++;
        if (bus.snk_data_o !== m_data) begin
          bad++; $display("FAIL rand_data c=%0d got=%h want=%h", c, bus.snk_data_o, m_data);
        end
      end
`ifdef MQ_OUT_SLOT_STATS_EN
      total++;
      if (st_ovf !== m_ovf || st_cmt !== m_cmt) begin
        bad++; $display("FAIL rand_stats c=%0d got=%0d/%0d want=%0d/%0d", c, st_ovf, st_cmt, m_ovf, m_cmt);
      end
`endif
    end
  endtask

  initial begin
    m_claimed  = 1'b0;
    m_data     = '0;
    m_data_chk = 1'b0;
    m_ovf      = '0;
    m_cmt      = '0;
    pend       = '0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_no_claim();
    test_purge();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
